// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared types and constants for the calc neuron feeder.
// Revision : 1.0
// ============================================================================

package calc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_SETTLE = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  localparam logic CALC_OP_ADD = 1'b1;
  localparam logic CALC_OP_SUB = 1'b0;

  localparam int DEF_VEC_LEN = 16;

endpackage

`default_nettype wire

// File: rtl/calc_feeder_buf.sv
`default_nettype none
// ============================================================================
// Module   : calc_feeder_buf
// Purpose  : One-entry holding buffer for a prefetched activation/weight pair.
// Revision : 1.0
// ============================================================================

module calc_feeder_buf
  import calc_pkg::*;
#(
  parameter int VEC_LEN = DEF_VEC_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               pop,
  input  logic [VEC_LEN-1:0] in_act,
  input  logic [VEC_LEN-1:0] in_wgt,
  output logic               full,
  output logic [VEC_LEN-1:0] buf_act,
  output logic [VEC_LEN-1:0] buf_wgt
);

  logic               full_q, full_d;
  logic [VEC_LEN-1:0] act_q, act_d;
  logic [VEC_LEN-1:0] wgt_q, wgt_d;

  // load and pop are mutually exclusive: load needs empty, pop needs full
  always_comb begin
    full_d = full_q;
    act_d  = act_q;
    wgt_d  = wgt_q;
    if (load) begin
      full_d = 1'b1;
      act_d  = in_act;
      wgt_d  = in_wgt;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      act_q  <= '0;
      wgt_q  <= '0;
    end else begin
      full_q <= full_d;
      act_q  <= act_d;
      wgt_q  <= wgt_d;
    end
  end

  assign full    = full_q;
  assign buf_act = act_q;
  assign buf_wgt = wgt_q;

endmodule

`default_nettype wire

// File: rtl/calc_feeder.sv
`default_nettype none
// ============================================================================
// Module   : calc_feeder
// Purpose  : Streams XNOR terms of an activation/weight pair into calc, LSB
//            first, and returns the activated neuron bit over valid/ready.
//            Optional one-entry prefetch buffer: CALC_FEEDER_PREFETCH_EN.
// Revision : 1.0
// ============================================================================

module calc_feeder
  import calc_pkg::*;
#(
  parameter int VEC_LEN = DEF_VEC_LEN,
  parameter int CNT_W   = $clog2(VEC_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VEC_LEN-1:0] in_act,
  input  logic [VEC_LEN-1:0] in_wgt,
  output logic               calc_1,
  output logic               calc_in,
  output logic               agg_clr,
  input  logic               acted_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_bit
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VEC_LEN-1:0] act_q, act_d;
  logic [VEC_LEN-1:0] wgt_q, wgt_d;
  logic               out_bit_q, out_bit_d;
  logic               accept;
  logic               buf_full;
  logic [VEC_LEN-1:0] buf_act, buf_wgt;

`ifdef CALC_FEEDER_PREFETCH_EN
  logic buf_load, buf_pop, load_direct;

  calc_feeder_buf #(
    .VEC_LEN (VEC_LEN)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (buf_load),
    .pop     (buf_pop),
    .in_act  (in_act),
    .in_wgt  (in_wgt),
    .full    (buf_full),
    .buf_act (buf_act),
    .buf_wgt (buf_wgt)
  );

  assign in_ready = ~buf_full;
  // A pair accepted while the shift registers are free bypasses the buffer
  assign buf_load = accept & ~load_direct;
`else
  assign buf_full = 1'b0;
  assign buf_act  = '0;
  assign buf_wgt  = '0;
  assign in_ready = (state_q == ST_IDLE);
`endif

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    act_d     = act_q;
    wgt_d     = wgt_q;
    out_bit_d = out_bit_q;
    calc_1    = 1'b0;
    calc_in   = CALC_OP_ADD;
    agg_clr   = 1'b0;
    out_valid = 1'b0;
`ifdef CALC_FEEDER_PREFETCH_EN
    buf_pop     = 1'b0;
    load_direct = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (buf_full) begin
          act_d   = buf_act;
          wgt_d   = buf_wgt;
          state_d = ST_CLEAR;
`ifdef CALC_FEEDER_PREFETCH_EN
          buf_pop = 1'b1;
`endif
        end else if (accept) begin
          act_d   = in_act;
          wgt_d   = in_wgt;
          state_d = ST_CLEAR;
`ifdef CALC_FEEDER_PREFETCH_EN
          load_direct = 1'b1;
`endif
        end
      end
      ST_CLEAR: begin
        agg_clr = 1'b1;
        cnt_d   = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        calc_1  = 1'b1;
        calc_in = (act_q[0] ^ wgt_q[0]) ? CALC_OP_SUB : CALC_OP_ADD;
        act_d   = act_q >> 1;
        wgt_d   = wgt_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // calc's accumulator is one register deep: acted_in is final now
        out_bit_d = acted_in;
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (buf_full) begin
            act_d   = buf_act;
            wgt_d   = buf_wgt;
            state_d = ST_CLEAR;
`ifdef CALC_FEEDER_PREFETCH_EN
            buf_pop = 1'b1;
`endif
          end else if (accept) begin
            act_d   = in_act;
            wgt_d   = in_wgt;
            state_d = ST_CLEAR;
`ifdef CALC_FEEDER_PREFETCH_EN
            load_direct = 1'b1;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      act_q     <= '0;
      wgt_q     <= '0;
      out_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      wgt_q     <= wgt_d;
      out_bit_q <= out_bit_d;
    end
  end

  assign out_bit = out_bit_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_feeder
// Purpose  : Directed self-checking bench for calc_feeder with a stubbed
//            acted_in; prefetch scenario under CALC_FEEDER_PREFETCH_EN.
// Revision : 1.0
// ============================================================================

module tb_calc_feeder;

  localparam int VEC_LEN = 16;
`ifdef CALC_FEEDER_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [VEC_LEN-1:0] in_act = '0;
  logic [VEC_LEN-1:0] in_wgt = '0;
  logic               calc_1;
  logic               calc_in;
  logic               agg_clr;
  logic               acted_in = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               out_bit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calc_feeder #(
    .VEC_LEN (VEC_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .in_wgt    (in_wgt),
    .calc_1    (calc_1),
    .calc_in   (calc_in),
    .agg_clr   (agg_clr),
    .acted_in  (acted_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit)
  );

  // Output vector order: {calc_1, calc_in, agg_clr, in_ready, out_valid, out_bit}
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({calc_1, calc_in, agg_clr, in_ready, out_valid, out_bit} !== 6'b010100) begin
      errors++;
      $display("FAIL reset_init got %b want 010100",
               {calc_1, calc_in, agg_clr, in_ready, out_valid, out_bit});
    end
    rst = 1'b1;
    @(negedge clk);
    in_act = 16'hFFFF; in_wgt = 16'h0000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if ({calc_1, calc_in} !== 2'b10) begin
      errors++;
      $display("FAIL reset_prestream got calc_1/calc_in %b want 10", {calc_1, calc_in});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({calc_1, calc_in, agg_clr, in_ready, out_valid, out_bit} !== 6'b010100) begin
      errors++;
      $display("FAIL reset_async got %b want 010100",
               {calc_1, calc_in, agg_clr, in_ready, out_valid, out_bit});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({calc_1, calc_in, agg_clr, in_ready, out_valid} !== 5'b01010) begin
        errors++;
        $display("FAIL reset_idle c=%0d got %b want 01010", c,
                 {calc_1, calc_in, agg_clr, in_ready, out_valid});
      end
    end
  endtask

  task automatic test_pattern(input string name, input logic [VEC_LEN-1:0] act,
                              input logic [VEC_LEN-1:0] wgt, input logic acted,
                              input logic exp_out);
    logic exp_clr, exp_c1, exp_ci, exp_ov, exp_ir;
    int   k;
    out_ready = 1'b1;
    acted_in  = acted;
    @(negedge clk);
    in_act = act; in_wgt = wgt; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready got %b want 1", name, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0; in_act = '0; in_wgt = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      k       = (c >= 2 && c <= 17) ? c - 2 : 0;
      exp_clr = (c == 1);
      exp_c1  = (c >= 2 && c <= 17);
      exp_ci  = exp_c1 ? ~(act[k] ^ wgt[k]) : 1'b1;
      exp_ov  = (c == 19);
      exp_ir  = PF ? 1'b1 : (c == 20);
      checks++;
      if ({agg_clr, calc_1, calc_in, out_valid, in_ready} !==
          {exp_clr, exp_c1, exp_ci, exp_ov, exp_ir}) begin
        errors++;
        $display("FAIL %s_cycle%0d got clr/c1/cin/ov/ir %b want %b", name, c,
                 {agg_clr, calc_1, calc_in, out_valid, in_ready},
                 {exp_clr, exp_c1, exp_ci, exp_ov, exp_ir});
      end
      if (c == 19) begin
        checks++;
        if (out_bit !== exp_out) begin
          errors++;
          $display("FAIL %s_out_bit got %b want %b", name, out_bit, exp_out);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    acted_in  = 1'b1;
    @(negedge clk);
    in_act = 16'hFFFF; in_wgt = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_wait got out_valid %b want 1 within 40 cycles", out_valid);
    end
    // out_bit must stay at the captured value even when acted_in moves
    acted_in = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_bit, in_ready} !== {1'b1, 1'b1, PF}) begin
        errors++;
        $display("FAIL bp_hold c=%0d got ov/bit/ir %b want %b", c,
                 {out_valid, out_bit, in_ready}, {1'b1, 1'b1, PF});
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release got ov/ir %b want 01", {out_valid, in_ready});
    end
  endtask

`ifndef CALC_FEEDER_PREFETCH_EN
  task automatic test_ignore_valid();
    logic [VEC_LEN-1:0] act, wgt;
    logic               exp_ci;
    act = 16'h00FF;
    wgt = 16'hFFFF;
    out_ready = 1'b1;
    acted_in  = 1'b0;
    @(negedge clk);
    in_act = act; in_wgt = wgt; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 17) begin
        exp_ci = ~(act[c-2] ^ wgt[c-2]);
        checks++;
        if ({calc_1, calc_in, in_ready} !== {1'b1, exp_ci, 1'b0}) begin
          errors++;
          $display("FAIL ignore_cycle%0d got c1/cin/ir %b want %b", c,
                   {calc_1, calc_in, in_ready}, {1'b1, exp_ci, 1'b0});
        end
      end
      if (c == 20) begin
        checks++;
        if ({agg_clr, in_ready, out_valid} !== 3'b010) begin
          errors++;
          $display("FAIL ignore_idle got clr/ir/ov %b want 010",
                   {agg_clr, in_ready, out_valid});
        end
      end
      // Conflicting pair offered mid-stream; must not be sampled
      in_valid = (c >= 3 && c <= 10);
      in_act   = 16'h0000;
      in_wgt   = 16'hFFFF;
    end
    in_valid = 1'b0;
  endtask
`endif

`ifdef CALC_FEEDER_PREFETCH_EN
  task automatic test_prefetch();
    int clr_n, ov_n, clr2, ov1, ov2;
    logic bit1, bit2;
    clr_n = 0; ov_n = 0; clr2 = -1; ov1 = -1; ov2 = -1;
    bit1 = 1'b0; bit2 = 1'b1;
    out_ready = 1'b1;
    acted_in  = 1'b1;
    @(negedge clk);
    in_act = 16'hFFFF; in_wgt = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk);
    #1 in_act = 16'h00FF; in_wgt = 16'hFFFF;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (agg_clr === 1'b1) begin
        clr_n++;
        if (clr_n == 2) clr2 = c;
      end
      if (out_valid === 1'b1) begin
        ov_n++;
        if (ov_n == 1) begin ov1 = c; bit1 = out_bit; end
        if (ov_n == 2) begin ov2 = c; bit2 = out_bit; end
      end
      if (c == 1) in_valid = 1'b0;
      if (c == 19) acted_in = 1'b0;
    end
    checks++;
    if (ov1 != 19) begin
      errors++;
      $display("FAIL pf_first_valid got cycle %0d want 19", ov1);
    end
    checks++;
    if (clr2 != 20) begin
      errors++;
      $display("FAIL pf_second_clr got cycle %0d want 20", clr2);
    end
    checks++;
    if (ov2 != 38) begin
      errors++;
      $display("FAIL pf_second_valid got cycle %0d want 38", ov2);
    end
    checks++;
    if ({bit1, bit2} !== 2'b10) begin
      errors++;
      $display("FAIL pf_bits got %b want 10", {bit1, bit2});
    end
  endtask
`endif

  initial begin
    test_reset();
    // All terms match: calc sum +16
    test_pattern("all_match", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    // 8 matches then 8 mismatches: calc sum 0
    test_pattern("half_match", 16'h00FF, 16'hFFFF, 1'b0, 1'b0);
    // Alternating match pattern, checks LSB-first ordering
    test_pattern("mixed", 16'hA5C3, 16'h0F0F, 1'b1, 1'b1);
    test_backpressure();
`ifndef CALC_FEEDER_PREFETCH_EN
    test_ignore_valid();
`else
    test_prefetch();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
